writeback_arbiter: RTL
======================

# writeback_arbiter

Parametrised register-file writeback stage. Merges the in-order M/W pipeline result with results from NUM_UNITS long-latency execution units (mult/div and successors) onto the single register-file write port. Pipeline writes always win. Unit results are accepted by valid/ready handshake, parked in a result FIFO, and drained on idle write-port cycles. A pending-destination mask is exported so issue logic can stall dependent instructions.

## Interface
- NUM_UNITS, 2, number of long-latency result channels (1..8)
- FIFO_DEPTH, 4, result FIFO entries (power of two, ≥2)
- DATA_W, 32, register data width
- clock  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-low
- mw_instruction  input  32  M/W instruction; opcode [31:27], Rd [26:22]
- mw_data_o  input  DATA_W  ALU/status result
- mw_data_d  input  DATA_W  load data
- mw_exception  input  1  pipeline exception, redirects write to r30
- unit_valid  input  NUM_UNITS  unit result valid
- unit_rd  input  5*NUM_UNITS  unit destination register
- unit_data  input  DATA_W*NUM_UNITS  unit result, or status code when excepting
- unit_exception  input  NUM_UNITS  unit exception, redirects write to r30
- unit_ready  output  NUM_UNITS  result accepted this cycle
- data_writeReg  output  DATA_W  register-file write data
- ctrl_writeReg  output  5  register-file write address
- ctrl_writeEnable  output  1  register-file write enable
- pending_mask  output  32  bit r set while a result for register r is queued
- fifo_count  output  $clog2(FIFO_DEPTH)+1  occupancy

## Operation
- Pipeline decode: R 00000, addi 00101, lw 01000 write Rd; jal 00011 writes r31; setx 10101 writes r30. mw_exception writes r30 for any opcode, with exception taking priority over jal. Data is mw_data_d for lw, else mw_data_o.
- pipe_we = decoded write and target ≠ r0.
- Unit arbitration: round-robin over asserted unit_valid, starting at rr_ptr. At most one grant per cycle. On a grant, rr_ptr ← grantee+1 mod NUM_UNITS.
- unit_ready[g] = 1 only for grantee g, and only when (FIFO not full) or (bypass taken) or (a dequeue occurs this cycle).
- Unit target is r30 if unit_exception, else unit_rd. A target of r0 is accepted and discarded.
- Write-port priority:
  - pipe_we → pipeline result.
  - Else FIFO non-empty → FIFO head, dequeued at the edge.
  - Else grant present → bypass: grantee result written directly, not enqueued.
  - Else ctrl_writeEnable = 0, ctrl_writeReg = 0, data_writeReg = 0.
- Enqueue: accepted, non-bypassed, non-r0 result. Simultaneous enqueue and dequeue are allowed when full, so count is unchanged.
- pending_mask = OR of one-hot targets of all valid FIFO entries, bit 0 forced to 0. A same-cycle bypass does not set a bit.
- Ordering: FIFO is strict FIFO; unit results retire in acceptance order.

## Timing
- Write-port outputs are combinational from mw_* inputs, FIFO head and grant. There is no internal pipeline register.
- Accept-to-write latency:
  - 0 cycles via bypass.
  - Otherwise ≥1 cycle, plus one per queued entry ahead, plus one per pipeline write in between.
- FIFO, rr_ptr and pending_mask update on the rising edge.
- Reset asserted, including mid-drain: FIFO empties, rr_ptr = 0, fifo_count = 0, pending_mask = 0, unit_ready = 0, ctrl_writeEnable = 0, ctrl_writeReg = 0, data_writeReg = 0. Queued results are lost; units must also be reset.
- Full FIFO, pipe_we = 1, units valid: no dequeue and no grant, so all unit_ready = 0. Units hold valid and data until ready.
- Pointers wrap modulo FIFO_DEPTH.

## Structure
- Package wb_pkg holds:
  - opcode constants OP_RTYPE, OP_ADDI, OP_LW, OP_JAL, OP_SETX;
  - REG_RSTATUS = 30, REG_RA = 31;
  - typedef wb_entry_t {rd[4:0], data[DATA_W-1:0]}.
- Sub-module wb_result_fifo: synchronous FIFO of wb_entry_t with count, full/empty, and a flattened entry-valid/rd vector for pending_mask.
- Round-robin arbiter and decode are inline.

## Test plan
- Pipeline only:
  - lw r5, mw_data_d = 0xDEAD → we = 1, reg 5, data 0xDEAD.
  - jal → reg 31.
  - add with mw_exception = 1, mw_data_o = 1 → reg 30, data 1.
  - add targeting r0 → we = 0.
- Bypass: FIFO empty, pipe idle, unit0 valid, rd = 7, data 42 → unit_ready[0] = 1 and a reg 7 / 42 write in the same cycle; fifo_count stays 0.
- Collision: pipe writes r3 while unit1 delivers r9.
  - Unit is accepted and fifo_count = 1, pending_mask[9] = 1.
  - Next idle cycle writes r9, count returns to 0.
- Fairness: both units valid continuously, pipe busy → grants alternate 0,1,0,1. With FIFO_DEPTH = 4, ready drops after 4 accepts.
- Full with drain: FIFO full, pipe idle, unit valid → dequeue and enqueue in the same edge; count stays 4 and order is preserved.
- Reset mid-operation: 3 entries queued, reset low asynchronously → outputs and fifo_count = 0 immediately. After release, no stale write.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared opcodes, register indices and result-entry type for the writeback stage.
package wb_pkg;
    localparam logic [4:0] OP_RTYPE    = 5'b00000;
    localparam logic [4:0] OP_ADDI     = 5'b00101;
    localparam logic [4:0] OP_LW       = 5'b01000;
    localparam logic [4:0] OP_JAL      = 5'b00011;
    localparam logic [4:0] OP_SETX     = 5'b10101;
    localparam logic [4:0] REG_RSTATUS = 5'd30;
    localparam logic [4:0] REG_RA      = 5'd31;
    localparam int WB_DATA_W = 32;
    typedef struct packed {
        logic [4:0]           rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_result_fifo.sv
// wb_result_fifo: strict-order result FIFO with occupancy and per-slot valid/rd view.
module wb_result_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = wb_entry_t,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  entry_t             push_entry,
    output entry_t             head,
    output logic               full,
    output logic               empty,
    output logic [AW:0]        count,
    output logic [DEPTH-1:0]   ent_valid,
    output logic [5*DEPTH-1:0] ent_rd
);
    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = count_q == (AW+1)'(DEPTH);
    assign empty = count_q == '0;

    // a slot is live when its distance from the read pointer is below the occupancy
    always_comb begin
        ent_valid = '0;
        ent_rd    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_valid[i]    = {1'b0, AW'(i) - rd_ptr_q} < count_q;
            ent_rd[5*i +: 5] = mem_q[i].rd;
        end
    end
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges the M/W pipeline result with long-latency unit results
// onto one register-file write port; pipeline wins, units queue or bypass.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int  NUM_UNITS  = 2,
    parameter int  FIFO_DEPTH = 4,
    parameter int  DATA_W     = 32,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1,
    localparam int PW         = NUM_UNITS > 1 ? $clog2(NUM_UNITS) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [31:0]                 mw_instruction,
    input  logic [DATA_W-1:0]           mw_data_o,
    input  logic [DATA_W-1:0]           mw_data_d,
    input  logic                        mw_exception,
    input  logic [NUM_UNITS-1:0]        unit_valid,
    input  logic [5*NUM_UNITS-1:0]      unit_rd,
    input  logic [DATA_W*NUM_UNITS-1:0] unit_data,
    input  logic [NUM_UNITS-1:0]        unit_exception,
    output logic [NUM_UNITS-1:0]        unit_ready,
    output logic [DATA_W-1:0]           data_writeReg,
    output logic [4:0]                  ctrl_writeReg,
    output logic                        ctrl_writeEnable,
    output logic [31:0]                 pending_mask,
    output logic [CW-1:0]               fifo_count
);
    typedef struct packed {
        logic [4:0]        rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic [4:0]              op, pipe_tgt, g_tgt;
    logic [DATA_W-1:0]       pipe_data, g_data;
    logic                    pipe_dec, pipe_we, grant_any, deq, bypass, byp_wr, accept, enq;
    logic [PW-1:0]           grant_idx, rr_ptr_q, rr_ptr_d;
    logic                    fifo_full, fifo_empty;
    entry_t                  push_entry, head;
    logic [FIFO_DEPTH-1:0]   ent_valid;
    logic [5*FIFO_DEPTH-1:0] ent_rd;
    logic                    unused_instr;

    assign unused_instr = ^mw_instruction[21:0];
    assign op           = mw_instruction[31:27];

    always_comb begin
        pipe_dec  = mw_exception || op inside {OP_RTYPE, OP_ADDI, OP_LW, OP_JAL, OP_SETX};
        pipe_tgt  = (mw_exception || op == OP_SETX) ? REG_RSTATUS :
                    op == OP_JAL ? REG_RA : mw_instruction[26:22];
        pipe_data = op == OP_LW ? mw_data_d : mw_data_o;
        pipe_we   = rst_n && pipe_dec && pipe_tgt != 5'd0;
    end

    always_comb begin
        int idx;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_UNITS;
            if (!grant_any && unit_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = PW'(idx);
            end
        end
        g_tgt  = unit_exception[grant_idx] ? REG_RSTATUS : unit_rd[int'(grant_idx)*5 +: 5];
        g_data = unit_data[int'(grant_idx)*DATA_W +: DATA_W];
    end

    // a grant only becomes an acceptance when its result has somewhere to go this cycle
    always_comb begin
        deq        = rst_n && !pipe_we && !fifo_empty;
        bypass     = rst_n && !pipe_we && fifo_empty && grant_any;
        byp_wr     = bypass && g_tgt != 5'd0;
        accept     = rst_n && grant_any && (!fifo_full || bypass || deq);
        enq        = accept && !bypass && g_tgt != 5'd0;
        rr_ptr_d   = accept ? PW'((int'(grant_idx) + 1) % NUM_UNITS) : rr_ptr_q;
        unit_ready = accept ? NUM_UNITS'(1) << grant_idx : '0;
        push_entry.rd   = g_tgt;
        push_entry.data = g_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr_q <= '0;
        else        rr_ptr_q <= rr_ptr_d;
    end

    always_comb begin
        ctrl_writeEnable = pipe_we || deq || byp_wr;
        ctrl_writeReg    = pipe_we ? pipe_tgt  : deq ? head.rd   : byp_wr ? g_tgt  : 5'd0;
        data_writeReg    = pipe_we ? pipe_data : deq ? head.data : byp_wr ? g_data : '0;
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++)
            if (ent_valid[i]) pending_mask[ent_rd[5*i +: 5]] = 1'b1;
        pending_mask[0] = 1'b0;
    end

    wb_result_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (enq),
        .pop        (deq),
        .push_entry (push_entry),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count),
        .ent_valid  (ent_valid),
        .ent_rd     (ent_rd)
    );
endmodule
